// File: rtl/alu_ops.sv
// Opcode encodings shared by the ALU datapath and anything that drives it.
// Any code not listed here selects a zero result.
package alu_ops;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU: res = a <op> b, zero for unrecognised opcodes.
// Shift amounts are b taken unsigned; amounts >= nbits saturate to fill.
module alu
    import alu_ops::*;
#(
    parameter int nbits = 8
) (
    input  logic [nbits-1:0] a,
    input  logic [nbits-1:0] b,
    input  logic [5:0]       op,
    output logic [nbits-1:0] res
);

    // Opcode decode and result selection
    always_comb begin
        res = {nbits{1'b0}};
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SRL:  res = a >> b;
            // A signed operand makes >>> replicate a[nbits-1], including for b >= nbits
            OP_SRA:  res = $unsigned($signed(a) >>> b);
            default: res = {nbits{1'b0}};
        endcase
    end

endmodule

// File: rtl/manejador_alu.sv
// Board front-end: captures operand A, operand B and the opcode from a shared
// bus under three level-sensitive load strobes, and drives the ALU result.
module manejador_alu #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       p_abc,
    input  logic [nbits-1:0] buf_in,
    output logic [nbits-1:0] dato_R
);

    logic [nbits-1:0] r_a;
    logic [nbits-1:0] r_b;
    logic [5:0]       r_op;
    logic [nbits-1:0] w_res;

    // Operand/opcode registers; reset wins over every strobe, strobes are independent
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a  <= {nbits{1'b0}};
            r_b  <= {nbits{1'b0}};
            r_op <= 6'd0;
        end else begin
            if (p_abc[2]) r_a  <= buf_in;
            if (p_abc[1]) r_b  <= buf_in;
            if (p_abc[0]) r_op <= buf_in[5:0];
        end
    end

    alu #(.nbits(nbits)) u_alu (
        .a   (r_a),
        .b   (r_b),
        .op  (r_op),
        .res (w_res)
    );

    assign dato_R = w_res;

endmodule

// File: tb/tb_manejador_alu.sv
// Self-checking bench for manejador_alu: directed cases with fixed expected
// values, then random strobes/data checked against a behavioural model.
module tb_manejador_alu;
    import alu_ops::*;

    logic       clk;
    logic       rst;
    logic [2:0] p_abc;
    logic [7:0] buf_in;
    logic [7:0] dato_R;

    int n_vec;
    int n_err;

    // Behavioural model state
    int m_a;
    int m_b;
    int m_op;

    manejador_alu #(.nbits(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .p_abc  (p_abc),
        .buf_in (buf_in),
        .dato_R (dato_R)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic int ref_alu(input int a, input int b, input int op);
        int sa;
        int sh;
        case (op)
            32'h20:  return (a + b) % 256;
            32'h22:  return (a - b + 256) % 256;
            32'h24:  return a & b;
            32'h25:  return a | b;
            32'h26:  return a ^ b;
            32'h27:  return 255 - (a | b);
            32'h02:  return (b >= 8) ? 0 : (a / (2 ** b));
            32'h03: begin
                sa = (a >= 128) ? a - 256 : a;
                sh = (b > 31) ? 31 : b;
                sa = sa >>> sh;
                return (sa + 256) % 256;
            end
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: dato_R=%02h required %02h", tag, got, exp);
        end
    endtask

    // Drive one step, advance one edge, update model, then settle for sampling
    task automatic step(input logic r, input logic [2:0] p, input logic [7:0] b);
        rst    = r;
        p_abc  = p;
        buf_in = b;
        @(posedge clk);
        if (r) begin
            m_a = 0; m_b = 0; m_op = 0;
        end else begin
            if (p[2]) m_a  = int'(b);
            if (p[1]) m_b  = int'(b);
            if (p[0]) m_op = int'(b) % 64;
        end
        #10;
    endtask

    logic [5:0] ops [8];

    initial begin
        logic       r;
        logic [2:0] p;
        logic [7:0] b;
        n_vec = 0; n_err = 0;
        m_a = 0; m_b = 0; m_op = 0;
        rst = 1'b1; p_abc = 3'b000; buf_in = 8'h00;
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
        ops[4] = OP_XOR; ops[5] = OP_NOR; ops[6] = OP_SRL; ops[7] = OP_SRA;

        // 1) reset
        step(1'b1, 3'b001, 8'h00); chk("reset", dato_R, 8'h00);
        step(1'b0, 3'b000, 8'h5A); chk("idle", dato_R, 8'h00);

        // 2) A=20, B=7, logic/arith ops
        step(1'b0, 3'b100, 8'd20); chk("ldA_noop", dato_R, 8'h00);
        step(1'b0, 3'b010, 8'd7);  chk("ldB_noop", dato_R, 8'h00);
        step(1'b0, 3'b001, {2'b00, OP_ADD}); chk("add", dato_R, 8'd27);
        step(1'b0, 3'b001, {2'b00, OP_SUB}); chk("sub", dato_R, 8'd13);
        step(1'b0, 3'b001, {2'b00, OP_AND}); chk("and", dato_R, 8'd4);
        step(1'b0, 3'b001, {2'b00, OP_OR});  chk("or",  dato_R, 8'd23);
        step(1'b0, 3'b001, {2'b00, OP_XOR}); chk("xor", dato_R, 8'd19);
        step(1'b0, 3'b001, {2'b00, OP_NOR}); chk("nor", dato_R, 8'hE8);
        step(1'b0, 3'b001, 8'h3F);           chk("badop", dato_R, 8'h00);

        // 3) hold with no strobe
        step(1'b0, 3'b001, {2'b00, OP_ADD}); chk("add2", dato_R, 8'd27);
        step(1'b0, 3'b000, {2'b00, OP_SUB}); chk("hold", dato_R, 8'd27);
        step(1'b0, 3'b001, {2'b00, OP_SUB}); chk("ldsub", dato_R, 8'd13);

        // 4) shifts with B=2
        step(1'b0, 3'b010, 8'd2);
        step(1'b0, 3'b100, 8'h60);
        step(1'b0, 3'b001, {2'b00, OP_SRL}); chk("srl60", dato_R, 8'h18);
        step(1'b0, 3'b001, {2'b00, OP_SRA}); chk("sra60", dato_R, 8'h18);
        step(1'b0, 3'b100, 8'hE0);           chk("sraE0", dato_R, 8'hF8);
        step(1'b0, 3'b001, {2'b00, OP_SRL}); chk("srlE0", dato_R, 8'h38);

        // 5) boundaries
        step(1'b0, 3'b100, 8'h80);
        step(1'b0, 3'b010, 8'd8);
        step(1'b0, 3'b001, {2'b00, OP_SRA}); chk("sra_b8", dato_R, 8'hFF);
        step(1'b0, 3'b001, {2'b00, OP_SRL}); chk("srl_b8", dato_R, 8'h00);
        step(1'b0, 3'b010, 8'd0);            chk("srl_b0", dato_R, 8'h80);
        step(1'b0, 3'b100, 8'h00);
        step(1'b0, 3'b010, 8'd1);
        step(1'b0, 3'b001, {2'b00, OP_SUB}); chk("sub_wrap", dato_R, 8'hFF);
        step(1'b0, 3'b100, 8'hFF);
        step(1'b0, 3'b001, {2'b00, OP_ADD}); chk("add_wrap", dato_R, 8'h00);

        // 6) multi-strobe and reset priority
        step(1'b0, 3'b111, 8'h20); chk("all3", dato_R, 8'd64);
        step(1'b1, 3'b111, 8'h20); chk("rstprio", dato_R, 8'h00);
        step(1'b0, 3'b000, 8'h20); chk("rsthold", dato_R, 8'h00);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 24) == 0);
            p = 3'($urandom_range(0, 7));
            b = 8'($urandom_range(0, 255));
            if (p[0] && ($urandom_range(0, 3) != 0))
                b = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 7)]};
            step(r, p, b);
            chk("rand", dato_R, 8'(ref_alu(m_a, m_b, m_op)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
